// File: rtl/channel_scan_sequencer.sv
// channel_scan_sequencer: walks an 8-bit channel mask and drives A/E
// of a 3-to-8 decoder, dwelling dwell+1 cycles on each enabled channel.
module channel_scan_sequencer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               mode,
  output logic [2:0]         A,
  output logic               E,
  output logic               busy,
  output logic               done
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DWELL = 1'b1;

  logic [0:0]         state;
  logic [7:0]         mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt;
  logic               mode_q;
  logic [7:0]         above;

  function automatic logic [2:0] lowest(input logic [7:0] m);
    logic [2:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = i[2:0];
    end
    return r;
  endfunction

  // enabled channels strictly above the current one
  assign above = mask_q & (8'hFE << A);

  // scan control: start/stop, dwell countdown, channel advance, wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      mask_q  <= '0;
      dwell_q <= '0;
      mode_q  <= 1'b0;
      cnt     <= '0;
      A       <= '0;
      E       <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && !stop) begin
            if (mask != 8'h00) begin
              mask_q  <= mask;
              dwell_q <= dwell;
              mode_q  <= mode;
              cnt     <= dwell;
              A       <= lowest(mask);
              E       <= 1'b1;
              busy    <= 1'b1;
              state   <= S_DWELL;
            end else begin
              done <= 1'b1;
            end
          end
        end
        S_DWELL: begin
          if (stop) begin
            E     <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (above != 8'h00) begin
            A   <= lowest(above);
            cnt <= dwell_q;
          end else if (!mode_q) begin
            E     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            A    <= lowest(mask_q);
            cnt  <= dwell_q;
            done <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
